// File: rtl/riscv_enc_pkg.sv
// riscv_enc_pkg: constants and types shared by the instruction encoder and decoder.
//   - RV32I major opcodes handled by the encoder
//   - NOP word emitted for unsupported opcodes (addi x0,x0,0)
//   - instr_fields_t: decoded field bundle, in decoder format
package riscv_enc_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // imm is already sign-extended; for B/J it is a byte offset.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: purely combinational field-to-word packer.
// Ports:
//   fields     in   decoded field bundle
//   instr      out  packed 32-bit instruction word (NOP for unsupported opcodes)
//   bad_opcode out  opcode is not one of the supported formats
//   bad_range  out  immediate does not fit its format (only with ENC_RANGE_CHECK_EN,
//                   otherwise tied 0)
module instr_pack
  import riscv_enc_pkg::*;
(
  input  instr_fields_t fields,
  output logic [31:0]   instr,
  output logic          bad_opcode,
  output logic          bad_range
);

  always_comb begin
    instr      = NOP;
    bad_opcode = 1'b0;
    case (fields.opcode)
      OP:
        instr = {fields.funct7, fields.rs2, fields.rs1, fields.funct3, fields.rd, fields.opcode};
      OP_IMM, JALR, LOAD:
        instr = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, fields.opcode};
      STORE:
        instr = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3, fields.imm[4:0],
                 fields.opcode};
      BRANCH:
        instr = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1, fields.funct3,
                 fields.imm[4:1], fields.imm[11], fields.opcode};
      LUI:
        instr = {fields.imm[31:12], fields.rd, fields.opcode};
      JAL:
        instr = {fields.imm[20], fields.imm[10:1], fields.imm[11], fields.imm[19:12],
                 fields.rd, fields.opcode};
      default:
        bad_opcode = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A value fits in N signed bits when every bit above bit N-1 equals the sign bit.
  logic fits_i, fits_b, fits_j, fits_u;
  assign fits_i = (fields.imm[31:11] == '0) || (fields.imm[31:11] == '1);
  assign fits_b = ((fields.imm[31:12] == '0) || (fields.imm[31:12] == '1)) && !fields.imm[0];
  assign fits_j = ((fields.imm[31:20] == '0) || (fields.imm[31:20] == '1)) && !fields.imm[0];
  assign fits_u = (fields.imm[11:0] == '0);

  always_comb begin
    bad_range = 1'b0;
    case (fields.opcode)
      OP_IMM, JALR, LOAD, STORE: bad_range = !fits_i;
      BRANCH:                    bad_range = !fits_b;
      JAL:                       bad_range = !fits_j;
      LUI:                       bad_range = !fits_u;
      default:                   bad_range = 1'b0;
    endcase
  end
`else
  assign bad_range = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streaming RISC-V field-to-word encoder with a 2-entry output FIFO.
// Parameters: BASE_ADDR (address of first word after reset), DEPTH (imem words, power of 2, >= 2).
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        field bundle handshake (in_ready is registered)
//   opcode, rd, rs1, rs2,
//   funct3, funct7, imm        decoded fields
//   out_valid / out_ready      encoded word handshake
//   out_instr, out_addr        encoded word and its byte address
//   err_opcode, err_range      sticky error flags, cleared only by reset
// Optional feature: define ENC_RANGE_CHECK_EN to enable immediate range checking
// (see instr_pack); otherwise err_range stays 0.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_opcode,
  output logic        err_range
);

  localparam int IDX_W = $clog2(DEPTH);

  instr_fields_t fields;
  logic [31:0]   packed_instr;
  logic          bad_opcode, bad_range;

  assign fields = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, imm: imm};

  instr_pack u_pack (
    .fields     (fields),
    .instr      (packed_instr),
    .bad_opcode (bad_opcode),
    .bad_range  (bad_range)
  );

  logic [31:0]      buf_instr_q [2], buf_instr_d [2];
  logic [31:0]      buf_addr_q  [2], buf_addr_d  [2];
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic             in_ready_q, in_ready_d;
  logic             err_opcode_q, err_opcode_d, err_range_q, err_range_d;
  logic             push, pop;

  always_comb begin
    push         = in_valid && in_ready_q;
    pop          = out_ready && (count_q != 2'd0);
    buf_instr_d  = buf_instr_q;
    buf_addr_d   = buf_addr_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    index_d      = index_q;
    err_opcode_d = err_opcode_q || (push && bad_opcode);
    err_range_d  = err_range_q  || (push && bad_range);
    if (push) begin
      buf_instr_d[wr_ptr_q] = packed_instr;
      buf_addr_d[wr_ptr_q]  = BASE_ADDR + (32'(index_q) << 2);
      wr_ptr_d              = ~wr_ptr_q;
      index_d               = index_q + IDX_W'(1);  // wraps modulo DEPTH
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    // Registered from the next count, so out_ready never reaches in_ready combinationally.
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_instr_q  <= '{default: '0};
      buf_addr_q   <= '{default: BASE_ADDR};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      index_q      <= '0;
      in_ready_q   <= 1'b0;
      err_opcode_q <= 1'b0;
      err_range_q  <= 1'b0;
    end else begin
      buf_instr_q  <= buf_instr_d;
      buf_addr_q   <= buf_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      index_q      <= index_d;
      in_ready_q   <= in_ready_d;
      err_opcode_q <= err_opcode_d;
      err_range_q  <= err_range_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (count_q != 2'd0);
  assign out_instr  = buf_instr_q[rd_ptr_q];
  assign out_addr   = buf_addr_q[rd_ptr_q];
  assign err_opcode = err_opcode_q;
  assign err_range  = err_range_q;

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  import riscv_enc_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          DEP  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  instr_fields_t fin = '0;
  logic          in_ready, out_valid, err_opcode, err_range;
  logic [31:0]   out_instr, out_addr;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(fin.opcode), .rd(fin.rd), .rs1(fin.rs1), .rs2(fin.rs2),
    .funct3(fin.funct3), .funct7(fin.funct7), .imm(fin.imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_opcode(err_opcode), .err_range(err_range)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_fields_t mk(input logic [6:0] op, input logic [4:0] rd_, rs1_, rs2_,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] im);
    instr_fields_t f;
    f = '{opcode: op, rd: rd_, rs1: rs1_, rs2: rs2_, funct3: f3, funct7: f7, imm: im};
    return f;
  endfunction

  // Reference encoder built from shifts and masks on the architectural field positions.
  function automatic logic [31:0] enc(input instr_fields_t f);
    logic [31:0] op, rdv, r1, r2, f3, f7, im;
    op = 32'(f.opcode); rdv = 32'(f.rd) << 7; r1 = 32'(f.rs1) << 15; r2 = 32'(f.rs2) << 20;
    f3 = 32'(f.funct3) << 12; f7 = 32'(f.funct7) << 25; im = f.imm;
    case (f.opcode)
      OP:                return f7 | r2 | r1 | f3 | rdv | op;
      OP_IMM, JALR, LOAD: return ((im & 32'hFFF) << 20) | r1 | f3 | rdv | op;
      STORE:  return (((im >> 5) & 32'h7F) << 25) | r2 | r1 | f3 | ((im & 32'h1F) << 7) | op;
      BRANCH: return (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | f3
                     | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 1) << 7) | op;
      LUI:    return (im & 32'hFFFF_F000) | rdv | op;
      JAL:    return (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                     | (((im >> 11) & 1) << 20) | (im & 32'h000F_F000) | rdv | op;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic bit known_op(input logic [6:0] o);
    return o inside {OP, OP_IMM, JALR, LOAD, STORE, BRANCH, LUI, JAL};
  endfunction

  function automatic bit imm_bad(input instr_fields_t f);
    longint s;
    s = longint'($signed(f.imm));
    case (f.opcode)
      OP_IMM, JALR, LOAD, STORE: return (s < -2048) || (s > 2047);
      BRANCH: return (s < -4096) || (s > 4095) || f.imm[0];
      JAL:    return (s < -(64'sd1 << 20)) || (s > (64'sd1 << 20) - 1) || f.imm[0];
      LUI:    return (f.imm & 32'hFFF) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Transaction-level model: queue of {word, addr}, next-address index, sticky flags.
  logic [63:0] mq[$];
  int          m_idx = 0;
  bit          m_ready = 1'b0;
  bit          m_eop = 1'b0, m_erng = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      mq.delete(); m_idx = 0; m_ready = 1'b0; m_eop = 1'b0; m_erng = 1'b0;
    end else begin
      acc = in_valid && m_ready;
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({enc(fin), BASE + 32'(4 * m_idx)});
        m_idx = (m_idx + 1) % DEP;
        if (!known_op(fin.opcode)) m_eop = 1'b1;
`ifdef ENC_RANGE_CHECK_EN
        if (imm_bad(fin)) m_erng = 1'b1;
`endif
      end
      m_ready = (mq.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(m_ready));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_instr", out_instr, mq[0][63:32]);
        chk("out_addr", out_addr, mq[0][31:0]);
      end
      chk("err_opcode", 32'(err_opcode), 32'(m_eop));
      chk("err_range", 32'(err_range), 32'(m_erng));
    end
  end

  task automatic send(input instr_fields_t f);
    int n;
    fin = f; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("send_ready", 32'(in_ready), 32'd1);
    if (in_ready) @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_fields_t f_add, f_addi, f_beq, f_lui, f_jal, f_sw, f_bad, f_big;
    logic exp_rng;
    f_add  = mk(OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
    f_addi = mk(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    f_beq  = mk(BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
    f_lui  = mk(LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    f_jal  = mk(JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
    f_sw   = mk(STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    f_bad  = mk(7'h7F,  5'd1, 5'd2, 5'd3, 3'd1, 7'd5, 32'd7);
    f_big  = mk(OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
`ifdef ENC_RANGE_CHECK_EN
    exp_rng = 1'b1;
`else
    exp_rng = 1'b0;
`endif

    chk("model_add",  enc(f_add),  32'h0020_81B3);
    chk("model_beq",  enc(f_beq),  32'hFE20_8EE3);
    chk("model_jal",  enc(f_jal),  32'h0080_00EF);
    chk("model_sw",   enc(f_sw),   32'h0020_A423);

    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr",  out_addr, BASE);
    chk("rst_err",       32'({err_opcode, err_range}), 32'd0);
    reset = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    send(f_add);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_instr", out_instr, 32'h0020_81B3);
    chk("add_addr",  out_addr, BASE);

    send(f_addi);
    chk("addi_instr", out_instr, 32'hFFF0_0093);
    chk("addi_addr",  out_addr, BASE + 32'd4);
    send(f_beq);
    chk("beq_instr", out_instr, 32'hFE20_8EE3);
    chk("beq_addr",  out_addr, BASE + 32'd8);
    @(negedge clk);

    out_ready = 1'b0;
    send(f_lui);
    send(f_jal);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(f_sw);
      begin
        repeat (3) @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_instr", out_instr, 32'h1234_52B7);
        chk("stall_addr",  out_addr, BASE + 32'd12);
        out_ready = 1'b1;
        @(negedge clk);
        chk("jal_instr", out_instr, 32'h0080_00EF);
        chk("jal_wrap_addr", out_addr, BASE);
      end
    join
    chk("sw_instr", out_instr, 32'h0020_A423);
    chk("sw_addr",  out_addr, BASE + 32'd4);

    send(f_bad);
    chk("bad_instr", out_instr, 32'h0000_0013);
    chk("bad_err",   32'(err_opcode), 32'd1);
    repeat (3) @(negedge clk);
    chk("bad_sticky", 32'(err_opcode), 32'd1);

    send(f_big);
    chk("big_instr", out_instr, 32'h8000_0093);
    chk("big_err_range", 32'(err_range), 32'(exp_rng));
    @(negedge clk);

    out_ready = 1'b0;
    send(f_add);
    send(f_addi);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_err",   32'(err_opcode), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    send(f_lui);
    chk("after_rst_addr",  out_addr, BASE);
    chk("after_rst_instr", out_instr, 32'h1234_52B7);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V instruction encoder, the inverse of the pipeline's field decoder: it accepts decoded instruction fields (opcode, rd, rs1, rs2, funct3, funct7, 32-bit imm) over a valid/ready handshake and emits packed 32-bit instruction words tagged with a sequential write address. It sits between the test/boot program generator and the instruction-memory write port, so programs can be built from fields rather than hand-assembled hex. A 2-entry output buffer decouples it from memory backpressure.

## Interface
- BASE_ADDR, 32'h0000_0000: address tagged on the first word after reset.
- DEPTH, 256: instruction-memory depth in words; address index wraps modulo DEPTH (power of two).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- opcode  in  7, rd/rs1/rs2  in  5 each, funct3  in  3, funct7  in  7, imm  in  32 — fields in decoder format (imm already sign-extended, byte offset for B/J).
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts word.
- out_instr  out  32  encoded instruction word.
- out_addr  out  32  byte address for out_instr.
- err_opcode  out  1  sticky: an unsupported opcode was accepted.
- err_range  out  1  sticky: an immediate did not fit its format.

## Operation
- Accept when in_valid && in_ready; the word is packed combinationally and pushed into the buffer on the same edge.
- Packing per opcode: OP {funct7,rs2,rs1,funct3,rd,op}; OP_IMM/JALR/LOAD {imm[11:0],rs1,funct3,rd,op}; STORE {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; BRANCH {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}; LUI {imm[31:12],rd,op}; JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
- Unused fields for a format are ignored (not checked).
- Any other opcode: emit NOP 32'h0000_0013, set err_opcode.
- Address: index counter increments per accepted bundle, modulo DEPTH; out_addr = BASE_ADDR + 4*index captured at accept. Wrap from DEPTH-1 to 0 is silent.
- Buffer: 2-entry FIFO, count 0..2; pop when out_valid && out_ready; in-order delivery.
- Sticky errors clear only on reset.

## Timing
- Reset: in_ready=0 during reset cycle, then 1; out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_opcode=0, err_range=0, count=0, index=0. Reset mid-stream discards buffered words.
- Latency: accept at edge N -> out_valid=1 from cycle N+1 (registered output).
- in_ready = (count != 2), registered-count based; no combinational path from out_ready to in_ready.
- Simultaneous push and pop: count unchanged; with out_ready held high sustained throughput is 1 word/cycle.
- out_instr/out_addr stable while out_valid && !out_ready.
- Error flags assert the cycle after the offending accept.

## Configuration
- ENC_RANGE_CHECK_EN defined: check I/S imm fits signed 12 bits; B fits signed 13 bits with imm[0]=0; J fits signed 21 bits with imm[0]=0; LUI imm[11:0]=0. Violation sets err_range; word still emitted with truncated fields.
- Undefined: no checks, err_range tied 0.

## Structure
- Package riscv_enc_pkg: opcode constants (OP, OP_IMM, JALR, LOAD, STORE, BRANCH, LUI, JAL), NOP constant, struct instr_fields_t bundling the input fields; shareable with the decoder.
- Sub-module instr_pack: pure combinational field-to-word packer plus range-check flags; instr_encoder holds handshake, FIFO, address counter and sticky errors.

## Test plan
- add x3,x1,x2 (op 0110011, rd3, rs1 1, rs2 2, f3 0, f7 0) -> out_instr 32'h002081B3, out_addr BASE_ADDR, valid 1 cycle after accept.
- addi x1,x0,-1 then beq x1,x2,-4 back-to-back, out_ready=1 -> 32'hFFF00093 @BASE, 32'hFE208EE3 @BASE+4, one word per cycle.
- lui x5,0x12345000 then jal x1,+8 with out_ready=0 -> in_ready drops after 2 accepts; third held; on release order 32'h123452B7, 32'h008000EF, third word, addrs consecutive.
- Opcode 7'h7F -> out_instr 32'h0000_0013, err_opcode=1 and stays 1 until reset.
- With ENC_RANGE_CHECK_EN: addi imm=2048 -> out_instr 32'h80000093, err_range=1; without macro err_range stays 0.
- DEPTH=4: push 5 words -> fifth out_addr = BASE_ADDR; assert reset with 2 words buffered -> out_valid=0, next word at BASE_ADDR.
